// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter/sequencer placing two clients onto a 16-entry
// single-port memory with a shared bidirectional data bus.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0/1, we0/1            level request (held until ack) and direction
//   addr0/1, wdata0/1        target location and write data
//   ack0/1                   one-cycle registered completion pulse
//   rdata0/1                 registered read data, held until next read
//   busy                     FSM not in IDLE
//   mem_cs, mem_write_en,
//   mem_read_en, mem_addr    memory controls, decoded from state
//   mem_data                 shared data bus; driven only in WRITE
module mem_port_arbiter #(
  parameter int DATA_SIZE = 8,
  parameter int ADDRESS   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDRESS-1:0]   addr0,
  input  logic [ADDRESS-1:0]   addr1,
  input  logic [DATA_SIZE-1:0] wdata0,
  input  logic [DATA_SIZE-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [DATA_SIZE-1:0] rdata0,
  output logic [DATA_SIZE-1:0] rdata1,
  output logic                 busy,
  output logic                 mem_cs,
  output logic                 mem_write_en,
  output logic                 mem_read_en,
  output logic [ADDRESS-1:0]   mem_addr,
  inout  wire  [DATA_SIZE-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, WRITE, RD_FETCH, RD_DRIVE} state_t;

  // Request latched at grant; later input changes are ignored until the next grant.
  typedef struct packed {
    logic                 id;
    logic [ADDRESS-1:0]   addr;
    logic [DATA_SIZE-1:0] wdata;
  } req_t;

  state_t                      state;
  req_t                        cur;
  logic                        last;
  logic [1:0]                  ack_q;
  logic [1:0][DATA_SIZE-1:0]   rdata_q;

  logic [1:0]                  req_in, we_in, req_eff;
  logic [1:0][ADDRESS-1:0]     addr_in;
  logic [1:0][DATA_SIZE-1:0]   wdata_in;
  logic                        gnt;

  assign req_in   = {req1, req0};
  assign we_in    = {we1, we0};
  assign addr_in  = {addr1, addr0};
  assign wdata_in = {wdata1, wdata0};

  // A client whose ack is out this cycle is still holding req; ignore it so
  // the dropping request is not serviced twice.
  assign req_eff = req_in & ~ack_q;

  // Both requesting: the one not granted last wins. Otherwise the lone requester.
  always_comb begin
    gnt = req_eff[1];
    if (req_eff == 2'b11) gnt = ~last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur     <= '0;
      last    <= 1'b1;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (|req_eff) begin
            cur.id    <= gnt;
            cur.addr  <= addr_in[gnt];
            cur.wdata <= wdata_in[gnt];
            last      <= gnt;
            state     <= we_in[gnt] ? WRITE : RD_FETCH;
          end
        end
        WRITE: begin
          ack_q[cur.id] <= 1'b1;
          state         <= IDLE;
        end
        // Memory loads its internal read register on this edge.
        RD_FETCH: state <= RD_DRIVE;
        RD_DRIVE: begin
          rdata_q[cur.id] <= mem_data;
          ack_q[cur.id]   <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

  // Controls come straight from the state register, so they are glitch-free.
  // WRITE and RD_DRIVE are never adjacent, which gives one cycle of bus
  // turnaround between the two drivers.
  assign busy         = (state != IDLE);
  assign mem_cs       = busy;
  assign mem_write_en = (state == WRITE);
  assign mem_read_en  = (state == RD_DRIVE);
  assign mem_addr     = busy ? cur.addr : '0;
  assign mem_data     = (state == WRITE) ? cur.wdata : 'z;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural two-phase memory on the shared
// bus, a vector table of single-client transactions, and hand sequences
// for contention, ack-cycle masking and reset during a read.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       busy, mem_cs, mem_write_en, mem_read_en;
  logic [3:0] mem_addr;
  wire  [7:0] mem_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         cl;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[8];

  mem_port_arbiter #(.DATA_SIZE(8), .ADDRESS(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mem_cs(mem_cs), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory model: write on cs&we, latch read register on cs with no enables,
  // drive bus on cs&re. Preloaded with {C, addr}.
  logic [7:0] mem [16];
  logic [7:0] rd_reg;
  logic       init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= {4'hC, 4'(i)};
    end else begin
      if (mem_cs && mem_write_en) mem[mem_addr] <= mem_data;
      if (mem_cs && !mem_write_en && !mem_read_en) rd_reg <= mem[mem_addr];
    end
  end
  assign mem_data = (mem_cs && mem_read_en) ? rd_reg : 'z;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: bus ownership every cycle, scoreboard pop on each ack.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!mem_cs)
          chk("idle_ctl", {mem_write_en, mem_read_en, mem_addr}, 0);
        if (mem_write_en || mem_read_en) begin
          if (sbq.size() == 0) chk("bus_unexpected", 1, 0);
          else begin
            e = sbq[0];
            chk("bus_addr", mem_addr, e.addr);
            chk("bus_dir", {mem_cs, mem_write_en, mem_read_en}, e.we ? 3'b110 : 3'b101);
            if (mem_write_en) chk("bus_wdata", mem_data, e.wdata);
            else              chk("bus_rdata", mem_data, e.exp);
          end
        end
        if (ack0 || ack1) begin
          chk("ack_onehot", ack0 & ack1, 0);
          if (sbq.size() == 0) chk("ack_unexpected", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("ack_id", ack1, e.cl);
            if (!e.we) chk(e.cl ? "rdata1" : "rdata0", e.cl ? rdata1 : rdata0, e.exp);
          end
        end
      end
    end
  end

  task automatic drive(input bit cl, input bit rq, input bit we, input logic [3:0] a,
                       input logic [7:0] d);
    if (cl) begin req1 = rq; we1 = we; addr1 = a; wdata1 = d; end
    else    begin req0 = rq; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  // Present one request, wait for its ack, check latency, drop req in the ack cycle.
  task automatic do_txn(input vec_t v, input bit hold);
    int  n = 0;
    bit  got = 0;
    @(negedge clk);
    drive(v.cl, 1'b1, v.we, v.addr, v.wdata);
    sbq.push_back(v);
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      got = v.cl ? ack1 : ack0;
    end
    chk(v.cl ? "latency1" : "latency0", n, v.we ? 2 : 3);
    if (!hold) drive(v.cl, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    int k, n;
    rst = 1'b1; init_mem = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_rdata", {rdata1, rdata0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctl", {mem_cs, mem_write_en, mem_read_en, mem_addr}, 0);
    rst = 1'b0; init_mem = 1'b0;

    //            cl we addr   wdata  exp
    tbl[0] = '{0, 1, 4'h3, 8'hA5, 8'h00};
    tbl[1] = '{0, 0, 4'h3, 8'h00, 8'hA5};
    tbl[2] = '{1, 1, 4'hF, 8'hFF, 8'h00};
    tbl[3] = '{1, 0, 4'hF, 8'h00, 8'hFF};
    tbl[4] = '{1, 0, 4'h0, 8'h00, 8'hC0};
    tbl[5] = '{0, 0, 4'h7, 8'h00, 8'hC7};
    tbl[6] = '{0, 1, 4'h8, 8'h3C, 8'h00};
    tbl[7] = '{1, 0, 4'h8, 8'h00, 8'h3C};
    for (int i = 0; i < 8; i++) do_txn(tbl[i], 1'b0);

    // Contention: both hold requests; service must alternate starting with 0.
    @(negedge clk);
    drive(0, 1, 1, 4'h1, 8'h11);
    drive(1, 1, 1, 4'h2, 8'h22);
    for (int i = 0; i < 4; i++) sbq.push_back('{bit'(i[0]), 1, i[0] ? 4'h2 : 4'h1,
                                               i[0] ? 8'h22 : 8'h11, 8'h00});
    k = 0; n = 0;
    while (k < 4 && n < 30) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) begin
        if (k == 0) chk("first_ack0", ack0, 1);
        k++;
      end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("contend_acks", k, 4);
    do_txn('{1, 0, 4'h1, 8'h00, 8'h11}, 1'b0);
    do_txn('{0, 0, 4'h2, 8'h00, 8'h22}, 1'b0);

    // Ack-cycle masking: req0 still high through the ack cycle.
    do_txn('{0, 1, 4'h5, 8'h5B, 8'h00}, 1'b1);
    @(negedge clk);
    chk("mask_busy", busy, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mask_noack", ack0, 0);
    do_txn('{0, 0, 4'h5, 8'h00, 8'h5B}, 1'b0);

    // Reset while in RD_FETCH.
    @(negedge clk);
    drive(0, 1, 0, 4'h3, 8'h00);
    @(negedge clk);
    chk("fetch_ctl", {busy, mem_cs, mem_write_en, mem_read_en, mem_addr}, {4'b1100, 4'h3});
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ctl", {mem_cs, mem_write_en, mem_read_en, mem_addr}, 0);
    chk("midrst_ack", {ack1, ack0}, 0);
    chk("midrst_rdata", {rdata1, rdata0}, 0);
    rst = 1'b0;
    do_txn('{0, 0, 4'h3, 8'h00, 8'hA5}, 1'b0);
    do_txn('{1, 0, 4'h0, 8'h00, 8'hC0}, 1'b0);

    repeat (3) @(negedge clk);
    chk("sbq_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter and sequencer for the 16-entry single-port memory with a shared tri-state data bus. It sits between two client blocks and the memory. It serialises their read/write requests and drives the memory's chip-select, write-enable, read-enable and address. It owns the bidirectional data bus: it drives the bus for writes and releases it for reads. It also runs the memory's two-phase read (fetch, then drive).

## Interface
- data_size, 8, width of data words
- address, 4, width of the memory address (16 locations)

- clk  input  1  single clock; all state changes on posedge
- rst  input  1  reset, synchronous, active-high
- req0 / req1  input  1  request from client 0 / 1; level, held until ack
- we0 / we1  input  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  input  address  target location; stable while req is high
- wdata0 / wdata1  input  data_size  write data; stable while req is high
- ack0 / ack1  output  1  one-cycle completion pulse, registered
- rdata0 / rdata1  output  data_size  read data, registered; valid with ack, held until that client's next read completes
- busy  output  1  high in any state other than IDLE
- mem_cs  output  1  memory chip select
- mem_write_en  output  1  memory write enable
- mem_read_en  output  1  memory read (bus-drive) enable
- mem_addr  output  address  memory address
- mem_data  inout  data_size  shared memory data bus

## Operation
- The FSM has four states: IDLE, WRITE, RD_FETCH and RD_DRIVE.
- Memory controls are decoded from the state register only:
  - IDLE: cs=0, we=0, re=0; mem_data = Z.
  - WRITE: cs=1, we=1, re=0; the arbiter drives the latched wdata onto mem_data.
  - RD_FETCH: cs=1, we=0, re=0; the memory latches its internal read register; mem_data = Z.
  - RD_DRIVE: cs=1, we=0, re=1; the memory drives mem_data; the arbiter never drives it.
- mem_addr holds the latched address in every non-IDLE state; it is 0 in IDLE.
- IDLE behaviour:
  - If any unmasked req is high, pick a winner and latch its addr, wdata, we and id.
  - Go to WRITE if we=1, else RD_FETCH.
- Transitions: WRITE → IDLE, with ack[id] set for the next cycle. RD_FETCH → RD_DRIVE. RD_DRIVE → IDLE, capturing mem_data into rdata[id] and setting ack[id].
- Arbitration:
  - A last-grant pointer resets to 1, so client 0 wins the first contention.
  - If only one request is present, that client wins.
  - If both are present, the client other than the last grant wins.
  - The pointer updates on every grant.
- Masking: in the cycle where ack[n] is high (the FSM is in IDLE), req[n] is ignored. The other client may still be granted in that cycle. This prevents re-servicing a request that is being dropped.
- Address wrap: none needed. Every address value is a valid location.

## Timing
- Reset values (after the rst edge): state IDLE; ack0=ack1=0; rdata0=rdata1=0; busy=0; mem_cs=mem_write_en=mem_read_en=0; mem_addr=0; mem_data=Z; last-grant=1.
- Write latency: req sampled at edge E0 → WRITE during E0..E1 → the memory writes at E1 → ack high during E1..E2. Ack arrives 2 cycles after sampling.
- Read latency: sampled at E0 → RD_FETCH → the memory latches at E1 → RD_DRIVE → rdata captured at E2 → ack high during E2..E3. Ack arrives 3 cycles after sampling.
- Throughput with back-to-back requests:
  - The FSM returns to IDLE in the ack cycle and can grant the other client in that same cycle.
  - A single client streaming requests gets one grant every 3 cycles (write) or 4 cycles (read).
- Bus turnaround: the arbiter drives mem_data only in WRITE, and the memory drives only in RD_DRIVE. The two states are never adjacent without passing through IDLE or RD_FETCH, so the arbiter and memory never contend.
- Reset mid-operation:
  - The FSM goes to IDLE at the rst edge and no ack is issued.
  - A write whose WRITE cycle coincides with the rst edge still lands in memory; this is accepted behaviour.
  - A read in progress is abandoned; rdata is cleared to 0.
- Changes to req, we, addr or wdata after a grant have no effect until the next grant.

## Test plan
- Write then read on client 0:
  - Stimulus: req0=1, we0=1, addr0=4'h3, wdata0=8'hA5, then a read of 4'h3.
  - Required: ack0 2 cycles after the write request is sampled; ack0 3 cycles after the read request is sampled, with rdata0=8'hA5. mem_data is Z in IDLE and RD_FETCH.
- Contention:
  - Stimulus: both clients continuously request; client 0 writes 8'h11 to 4'h1, client 1 writes 8'h22 to 4'h2.
  - Required: grants alternate 0,1,0,1. The first ack goes to ack0. Later reads return 8'h11 and 8'h22.
- Ack-cycle masking:
  - Stimulus: req0 is held high for one extra cycle after ack0.
  - Required: no second grant to client 0 in the ack cycle; a new request presented in the following cycle is serviced normally.
- Bus ownership:
  - Check: monitor mem_data every cycle across mixed traffic.
  - Required: the arbiter drives only in WRITE and mem_read_en is high only in RD_DRIVE. The bus is never X due to contention.
- Reset during RD_FETCH:
  - Stimulus: rst=1 for one cycle.
  - Required: next cycle state IDLE, all memory controls 0, ack0=ack1=0, rdata cleared. A subsequent read of 4'h3 still returns 8'hA5.
- Last location:
  - Stimulus: client 1 writes 8'hFF to address 4'hF, then reads it back.
  - Required: rdata1=8'hFF; location 4'h0 is unchanged.
